// File: rtl/fx2_host_emu_pkg.sv
// Shared definitions for the FX2/host emulator: FSM state encoding,
// command-byte layout, length-field size and FIFO-select encodings.
package fx2_host_emu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_LEN3  = 3'd2,
        ST_LEN2  = 3'd3,
        ST_LEN1  = 3'd4,
        ST_LEN0  = 3'd5,
        ST_WDATA = 3'd6,
        ST_RDATA = 3'd7
    } fx2_state_t;

    // Bit of the command byte that flags a channel read.
    localparam int CMD_READ_BIT = 7;

    // Number of bytes in the big-endian length field.
    localparam int LEN_BYTES = 4;

    // fx2FifoSel encodings.
    localparam logic FIFO_SEL_EP6OUT = 1'b0;
    localparam logic FIFO_SEL_EP8IN  = 1'b1;

    // Byte idx (0 = least significant) of the 32-bit length.
    function automatic logic [7:0] len_byte(input logic [31:0] len, input logic [1:0] idx);
        return len[8*idx +: 8];
    endfunction

endpackage

// File: rtl/fx2_host_emu_if.sv
// User-side ports of the emulator: request handshake, write payload stream
// and read payload stream.
//
// Handshake rule for every stream here: a transfer happens on a rising edge
// where valid and ready are both 1; a source holds valid and its data stable
// until that edge.
interface fx2_host_emu_if;

    logic        reqValid_in;
    logic        reqReady_out;
    logic        reqIsRead_in;
    logic [6:0]  reqChan_in;
    logic [31:0] reqLength_in;

    logic [7:0]  wrData_in;
    logic        wrValid_in;
    logic        wrReady_out;

    logic [7:0]  rdData_out;
    logic        rdValid_out;
    logic        rdReady_in;

    // User logic issuing requests.
    modport master (
        output reqValid_in, reqIsRead_in, reqChan_in, reqLength_in,
        output wrData_in, wrValid_in, rdReady_in,
        input  reqReady_out, wrReady_out, rdData_out, rdValid_out
    );

    // The emulator.
    modport slave (
        input  reqValid_in, reqIsRead_in, reqChan_in, reqLength_in,
        input  wrData_in, wrValid_in, rdReady_in,
        output reqReady_out, wrReady_out, rdData_out, rdValid_out
    );

endinterface

// File: rtl/fx2_ep_buffer.sv
// Small synchronous byte FIFO holding EP8IN captures until the user drains
// them. Output data comes straight from the storage flops; input side is
// valid + full (ready is simply !full).
module fx2_ep_buffer #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       full,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push;
    logic                  pop;

    assign full      = (count_q == FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid && !full;
    assign pop       = out_valid && out_ready;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so rdData reads 0x00 afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fx2_host_emu.sv
// FX2 + host stand-in: turns channel requests into the CommFPGA command
// stream on EP6OUT and collects read payload from EP8IN.
// Optional link byte counters: define FX2_HOST_EMU_COUNTERS_EN.
module fx2_host_emu
    import fx2_host_emu_pkg::*;
#(
    parameter int IN_DEPTH_LOG2 = 2
) (
    input  logic                fx2Clk_in,
    input  logic                reset_in,
    fx2_host_emu_if.slave       usr,
    output logic                busy_out,
    output fx2_state_t          state_dbg_out,
    input  logic                fx2FifoSel_in,
    inout  wire  [7:0]          fx2Data_io,
    input  logic                fx2Read_in,
    output logic                fx2GotData_out,
    input  logic                fx2Write_in,
    output logic                fx2GotRoom_out,
    input  logic                fx2PktEnd_in
`ifdef FX2_HOST_EMU_COUNTERS_EN
    ,
    output logic [31:0]         txCount_out,
    output logic [31:0]         rxCount_out
`endif
);

    fx2_state_t  state_q, state_d;
    logic        is_read_q, is_read_d;
    logic [6:0]  chan_q, chan_d;
    logic [31:0] remaining_q, remaining_d;

    logic [7:0]  cmd_byte;
    logic [7:0]  out_byte;
    logic        got_data;
    logic        out_phase;
    logic        consume;
    logic        capture;
    logic        drive_en;
    logic        buf_full;

    // Packet end is never needed: the remaining count alone ends a read.
    logic        unused_pktend;
    assign unused_pktend = fx2PktEnd_in;

    // Command byte: read flag on top of the channel number.
    always_comb begin
        cmd_byte               = {1'b0, chan_q};
        cmd_byte[CMD_READ_BIT] = is_read_q;
    end

    // Byte currently offered on EP6OUT and whether it is available.
    always_comb begin
        out_byte  = 8'h00;
        got_data  = 1'b0;
        out_phase = 1'b1;
        case (state_q)
            ST_CMD:   begin out_byte = cmd_byte; got_data = 1'b1; end
            ST_LEN3:  begin out_byte = len_byte(remaining_q, 2'(LEN_BYTES - 1)); got_data = 1'b1; end
            ST_LEN2:  begin out_byte = len_byte(remaining_q, 2'd2); got_data = 1'b1; end
            ST_LEN1:  begin out_byte = len_byte(remaining_q, 2'd1); got_data = 1'b1; end
            ST_LEN0:  begin out_byte = len_byte(remaining_q, 2'd0); got_data = 1'b1; end
            ST_WDATA: begin out_byte = usr.wrData_in; got_data = usr.wrValid_in; end
            default:  out_phase = 1'b0;
        endcase
    end

    assign consume  = (fx2FifoSel_in == FIFO_SEL_EP6OUT) && !fx2Read_in && got_data;
    assign capture  = (fx2FifoSel_in == FIFO_SEL_EP8IN) && !fx2Write_in && fx2GotRoom_out;

    // Only drive the bus while there is an out byte to present; in IDLE and
    // RDATA (and right after reset) the pins float even with read held low.
    assign drive_en   = (fx2FifoSel_in == FIFO_SEL_EP6OUT) && !fx2Read_in && out_phase;
    assign fx2Data_io = drive_en ? out_byte : 8'hzz;

    assign fx2GotData_out   = got_data;
    assign fx2GotRoom_out   = (state_q == ST_RDATA) && !buf_full;
    assign usr.wrReady_out  = (state_q == ST_WDATA) && consume;
    assign usr.reqReady_out = (state_q == ST_IDLE) && !reset_in;
    assign busy_out         = (state_q != ST_IDLE);
    assign state_dbg_out    = state_q;

    // Command sequencer: request latch, header bytes, payload countdown.
    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        chan_d      = chan_q;
        remaining_d = remaining_q;
        case (state_q)
            ST_IDLE: begin
                if (usr.reqValid_in) begin
                    is_read_d   = usr.reqIsRead_in;
                    chan_d      = usr.reqChan_in;
                    remaining_d = usr.reqLength_in;
                    state_d     = ST_CMD;
                end
            end
            ST_CMD:  if (consume) state_d = ST_LEN3;
            ST_LEN3: if (consume) state_d = ST_LEN2;
            ST_LEN2: if (consume) state_d = ST_LEN1;
            ST_LEN1: if (consume) state_d = ST_LEN0;
            ST_LEN0: begin
                if (consume) begin
                    if (remaining_q == '0)  state_d = ST_IDLE;
                    else if (is_read_q)     state_d = ST_RDATA;
                    else                    state_d = ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (consume) begin
                    if (remaining_q == 32'd1) state_d = ST_IDLE;
                    if (remaining_q != '0)    remaining_d = remaining_q - 32'd1;
                end
            end
            ST_RDATA: begin
                if (capture) begin
                    if (remaining_q == 32'd1) state_d = ST_IDLE;
                    if (remaining_q != '0)    remaining_d = remaining_q - 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset aborts any transfer in flight.
    always_ff @(posedge fx2Clk_in) begin
        if (reset_in) begin
            state_q     <= ST_IDLE;
            is_read_q   <= 1'b0;
            chan_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            is_read_q   <= is_read_d;
            chan_q      <= chan_d;
            remaining_q <= remaining_d;
        end
    end

    fx2_ep_buffer #(
        .DEPTH_LOG2 (IN_DEPTH_LOG2)
    ) u_in_buf (
        .clk       (fx2Clk_in),
        .rst       (reset_in),
        .in_data   (fx2Data_io),
        .in_valid  (capture),
        .full      (buf_full),
        .out_data  (usr.rdData_out),
        .out_valid (usr.rdValid_out),
        .out_ready (usr.rdReady_in)
    );

`ifdef FX2_HOST_EMU_COUNTERS_EN
    logic [31:0] tx_count_q, tx_count_d;
    logic [31:0] rx_count_q, rx_count_d;

    // Free-running link byte counters, wrapping at 2^32.
    always_comb begin
        tx_count_d = tx_count_q + {31'd0, consume};
        rx_count_d = rx_count_q + {31'd0, capture};
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge fx2Clk_in) begin
        if (reset_in) begin
            tx_count_q <= '0;
            rx_count_q <= '0;
        end else begin
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
        end
    end

    assign txCount_out = tx_count_q;
    assign rxCount_out = rx_count_q;
`else
    // Link byte counters are not built.
`endif

endmodule

// File: tb/tb_fx2_host_emu.sv
// Bench for fx2_host_emu: table of request vectors plus hand-written
// backpressure and reset-abort sequences.
module tb_fx2_host_emu;
    import fx2_host_emu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT hookup ----------------
    fx2_host_emu_if usr ();
    logic       busy;
    fx2_state_t st_dbg;
    logic       sel, rd_n, wr_n, pktend;
    logic       gotdata, gotroom;
    wire  [7:0] bus;
    logic       tb_drv;
    logic [7:0] tb_bus;
    assign bus = tb_drv ? tb_bus : 8'hzz;
`ifdef FX2_HOST_EMU_COUNTERS_EN
    logic [31:0] tx_cnt, rx_cnt;
`endif

    fx2_host_emu #(.IN_DEPTH_LOG2(2)) dut (
        .fx2Clk_in      (clk),
        .reset_in       (rst),
        .usr            (usr),
        .busy_out       (busy),
        .state_dbg_out  (st_dbg),
        .fx2FifoSel_in  (sel),
        .fx2Data_io     (bus),
        .fx2Read_in     (rd_n),
        .fx2GotData_out (gotdata),
        .fx2Write_in    (wr_n),
        .fx2GotRoom_out (gotroom),
        .fx2PktEnd_in   (pktend)
`ifdef FX2_HOST_EMU_COUNTERS_EN
        ,
        .txCount_out    (tx_cnt),
        .rxCount_out    (rx_cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int passes = 0;
    int tx_seen = 0;
    int rx_seen = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rd_exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic        is_read;
        logic [6:0]  chan;
        logic [31:0] len;
        logic [39:0] hdr;   // expected cmd + length bytes, first byte on top
        logic [47:0] data;  // payload, first byte on top
        int          stall_at;
    } vec_t;

    vec_t vecs[5];
    logic [7:0] bp_data [6];

    function automatic logic [7:0] get_byte(input logic [47:0] d, input int i);
        if (i > 5 || i < 0) return 8'h00;
        return d[8*(5-i) +: 8];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        usr.reqValid_in  = 1'b0;
        usr.reqIsRead_in = 1'b0;
        usr.reqChan_in   = '0;
        usr.reqLength_in = '0;
        usr.wrValid_in   = 1'b0;
        usr.wrData_in    = '0;
        usr.rdReady_in   = 1'b1;
        sel    = 1'b0;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        pktend = 1'b1;
        tb_drv = 1'b0;
        tb_bus = '0;
    endtask

    task automatic send_req(input logic is_read, input logic [6:0] chan, input logic [31:0] len);
        @(negedge clk);
        usr.reqValid_in  = 1'b1;
        usr.reqIsRead_in = is_read;
        usr.reqChan_in   = chan;
        usr.reqLength_in = len;
        #1;
        check("req_ready_idle", usr.reqReady_out, 1'b1);
        @(negedge clk);
        usr.reqValid_in = 1'b0;
    endtask

    task automatic take_header(input logic [39:0] hdr);
        int n;
        int cyc;
        n = 0;
        cyc = 0;
        while (n < 5 && cyc < 20) begin
            cyc++;
            sel = 1'b0; rd_n = 1'b0; wr_n = 1'b1; tb_drv = 1'b0;
            usr.wrValid_in = 1'b0;
            #1;
            if (gotdata) begin
                check("hdr_byte", bus, hdr[8*(4-n) +: 8]);
                n++;
                tx_seen++;
            end
            @(negedge clk);
        end
        check("hdr_complete", n, 5);
    endtask

    task automatic run_vec(input vec_t v);
        int wi, ri, hdr_seen, stall_cnt, cyc;
        logic cap_prev, last_cap;
        exp_q.delete();
        rd_exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(v.hdr[8*(4-i) +: 8]);
        for (int i = 0; i < int'(v.len); i++) begin
            if (v.is_read) rd_exp_q.push_back(get_byte(v.data, i));
            else           exp_q.push_back(get_byte(v.data, i));
        end
        send_req(v.is_read, v.chan, v.len);
        wi = 0; ri = 0; hdr_seen = 0; stall_cnt = 0; cyc = 0;
        cap_prev = 1'b0; last_cap = 1'b0;
        while ((exp_q.size() > 0 || rd_exp_q.size() > 0 || last_cap) && cyc < 200) begin
            cyc++;
            usr.rdReady_in = 1'b1;
            if (exp_q.size() > 0) begin
                sel = 1'b0; rd_n = 1'b0; wr_n = 1'b1; tb_drv = 1'b0; pktend = 1'b1;
                if (hdr_seen >= 5 && wi == v.stall_at && stall_cnt < 5) begin
                    usr.wrValid_in = 1'b0;
                end else begin
                    usr.wrValid_in = (hdr_seen >= 5);
                    usr.wrData_in  = get_byte(v.data, wi);
                end
            end else begin
                usr.wrValid_in = 1'b0;
                sel = 1'b1; rd_n = 1'b1;
                if (v.is_read && ri < int'(v.len)) begin
                    wr_n = 1'b0; tb_drv = 1'b1; tb_bus = get_byte(v.data, ri); pktend = 1'b0;
                end else begin
                    wr_n = 1'b1; tb_drv = 1'b0; pktend = 1'b1;
                end
            end
            #1;
            if (last_cap) begin
                check("busy_after_last_capture", busy, 1'b0);
                last_cap = 1'b0;
            end
            if (cap_prev) check("rd_valid_latency", usr.rdValid_out, 1'b1);
            cap_prev = 1'b0;
            if (sel == 1'b0) begin
                if (hdr_seen >= 5 && wi == v.stall_at && stall_cnt < 5) begin
                    check("got_data_in_stall", gotdata, 1'b0);
                    stall_cnt++;
                end else if (gotdata) begin
                    check("ep6out_byte", bus, exp_q.pop_front());
                    check("wr_ready", usr.wrReady_out, (hdr_seen >= 5));
                    if (hdr_seen >= 5) wi++;
                    else hdr_seen++;
                    tx_seen++;
                end
            end else if (!wr_n && gotroom) begin
                check("busy_during_read", busy, 1'b1);
                ri++;
                rx_seen++;
                cap_prev = 1'b1;
                if (ri == int'(v.len)) last_cap = 1'b1;
            end
            if (usr.rdValid_out && usr.rdReady_in) begin
                if (rd_exp_q.size() > 0) check("rd_data", usr.rdData_out, rd_exp_q.pop_front());
                else check("rd_spurious_valid", usr.rdValid_out, 1'b0);
            end
            @(negedge clk);
        end
        check("txn_complete", exp_q.size() + rd_exp_q.size(), 0);
        #1;
        check("end_busy", busy, 1'b0);
        check("end_req_ready", usr.reqReady_out, 1'b1);
        check("end_state", st_dbg, ST_IDLE);
        check("end_got_data", gotdata, 1'b0);
        drive_idle();
    endtask

    // Hard stop in case something hangs outside the bounded loops.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        int ri, cyc;

        vecs[0] = '{1'b0, 7'h05, 32'd3, 40'h05_0000_0003, 48'hA1B2C3_000000, -1};
        vecs[1] = '{1'b1, 7'h02, 32'd2, 40'h82_0000_0002, 48'h1122_00000000, -1};
        vecs[2] = '{1'b0, 7'h01, 32'd0, 40'h01_0000_0000, 48'h0, -1};
        vecs[3] = '{1'b0, 7'h7F, 32'd6, 40'h7F_0000_0006, 48'hD0D1D2D3D4D5, 2};
        vecs[4] = '{1'b1, 7'h40, 32'd1, 40'hC0_0000_0001, 48'h5A_0000000000, -1};
        bp_data = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};

        // reset
        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready_low", usr.reqReady_out, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_req_ready", usr.reqReady_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_state", st_dbg, ST_IDLE);
        check("rst_got_data", gotdata, 1'b0);
        check("rst_got_room", gotroom, 1'b0);
        check("rst_wr_ready", usr.wrReady_out, 1'b0);
        check("rst_rd_valid", usr.rdValid_out, 1'b0);
        check("rst_rd_data", usr.rdData_out, 8'h00);

        // table-driven transactions
        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        // backpressure: read 6 with the user stalled
        send_req(1'b1, 7'h03, 32'd6);
        take_header(40'h83_0000_0006);
        usr.rdReady_in = 1'b0;
        ri = 0;
        cyc = 0;
        while (cyc < 20) begin
            cyc++;
            sel = 1'b1; rd_n = 1'b1; wr_n = 1'b0; tb_drv = 1'b1; tb_bus = bp_data[ri];
            #1;
            if (!gotroom) break;
            ri++;
            rx_seen++;
            @(negedge clk);
        end
        check("bp_captures_before_full", ri, 4);
        check("bp_rd_valid_held", usr.rdValid_out, 1'b1);
        check("bp_rd_data_held", usr.rdData_out, 8'h31);
        @(negedge clk);
        #1;
        check("bp_room_still_zero", gotroom, 1'b0);
        check("bp_rd_data_stable", usr.rdData_out, 8'h31);
        @(negedge clk);
        rd_exp_q.delete();
        for (int i = 0; i < 6; i++) rd_exp_q.push_back(bp_data[i]);
        usr.rdReady_in = 1'b1;
        cyc = 0;
        while (rd_exp_q.size() > 0 && cyc < 40) begin
            cyc++;
            if (ri < 6) begin wr_n = 1'b0; tb_drv = 1'b1; tb_bus = bp_data[ri]; end
            else begin wr_n = 1'b1; tb_drv = 1'b0; end
            #1;
            if (!wr_n && gotroom) begin ri++; rx_seen++; end
            if (usr.rdValid_out) check("bp_rd_data", usr.rdData_out, rd_exp_q.pop_front());
            @(negedge clk);
        end
        check("bp_drained", rd_exp_q.size(), 0);
        #1;
        check("bp_end_busy", busy, 1'b0);
        drive_idle();

`ifdef FX2_HOST_EMU_COUNTERS_EN
        #1;
        check("tx_count", tx_cnt, tx_seen);
        check("rx_count", rx_cnt, rx_seen);
`endif

        // reset in the middle of a write payload
        send_req(1'b0, 7'h09, 32'h0102_0304);
        take_header(40'h09_0102_0304);
        sel = 1'b0; rd_n = 1'b0;
        usr.wrValid_in = 1'b1;
        usr.wrData_in  = 8'hE1;
        #1;
        check("abort_wr_ready", usr.wrReady_out, 1'b1);
        check("abort_byte0", bus, 8'hE1);
        @(negedge clk);
        usr.wrData_in = 8'hE2;
        #1;
        check("abort_byte1", bus, 8'hE2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_req_ready_in_reset", usr.reqReady_out, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_state", st_dbg, ST_IDLE);
        check("abort_busy", busy, 1'b0);
        check("abort_got_data", gotdata, 1'b0);
        check("abort_wr_ready_low", usr.wrReady_out, 1'b0);
        check("abort_rd_valid", usr.rdValid_out, 1'b0);
        check("abort_req_ready", usr.reqReady_out, 1'b1);
`ifdef FX2_HOST_EMU_COUNTERS_EN
        check("abort_tx_count", tx_cnt, 0);
        check("abort_rx_count", rx_cnt, 0);
`endif
        drive_idle();

        // link works again after the abort
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
